// File: rtl/ifetch_mem_pkg.sv
// Shared types and sizes for the instruction-fetch memory responder.
package ifetch_mem_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
    localparam int unsigned LANE_W     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ifetch_mem_responder_if.sv
// Fetch-request and byte-RAM signals between fetch unit, RAM and responder.
interface ifetch_mem_responder_if #(
    parameter int unsigned MEM_AW = 18
);
    import ifetch_mem_pkg::*;

    logic                flush;
    logic                asking;
    logic [ADDR_W-1:0]   addr;
    logic [MEM_AW-1:0]   mem_a;
    logic                mem_rd_en;
    logic [BYTE_W-1:0]   mem_din;
    logic [WORD_W-1:0]   data;
    logic                data_ready;
    logic                busy;

    // Fetch unit plus RAM side.
    modport master (
        output flush, asking, addr, mem_din,
        input  mem_a, mem_rd_en, data, data_ready, busy
    );

    modport slave (
        input  flush, asking, addr, mem_din,
        output mem_a, mem_rd_en, data, data_ready, busy
    );

endinterface

// File: rtl/fetch_byte_assembler.sv
// Collects byte-wide RAM returns into the selected lane of a 32-bit word.
module fetch_byte_assembler
    import ifetch_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_capture_en,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [BYTE_W-1:0] i_din,
    output logic [WORD_W-1:0] o_word
);

    logic [WORD_W-1:0] r_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
        end else if (i_clear) begin
            r_word <= '0;
        end else if (i_capture_en) begin
            r_word[BYTE_W*i_lane +: BYTE_W] <= i_din;
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/ifetch_mem_responder.sv
// Fetch responder: four byte reads per request, little-endian word assembly,
// one-entry pending buffer and flush abort.
module ifetch_mem_responder
    import ifetch_mem_pkg::*;
#(
    parameter int unsigned MEM_AW = 18,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    ifetch_mem_responder_if.slave   bus
);

    if (RD_LAT != 1) begin : g_bad_rd_lat
        $error("ifetch_mem_responder: RD_LAT must be 1");
    end

    state_t              r_state,      w_state_nxt;
    logic [LANE_W-1:0]   r_idx,        w_idx_nxt;
    logic [LANE_W-1:0]   r_cap_lane,   w_cap_lane_nxt;
    logic [MEM_AW-1:0]   r_base,       w_base_nxt;
    logic                r_pend_valid, w_pend_valid_nxt;
    logic [MEM_AW-1:0]   r_pend_addr,  w_pend_addr_nxt;
    logic [MEM_AW-1:0]   r_mem_a,      w_mem_a_nxt;
    logic                r_mem_rd_en,  w_mem_rd_en_nxt;
    logic [WORD_W-1:0]   r_data,       w_data_nxt;
    logic                r_data_ready, w_data_ready_nxt;
    logic                r_busy,       w_busy_nxt;

    logic [MEM_AW-1:0]   w_req_addr;
    logic [WORD_W-1:0]   w_word;
    logic                w_capture_en;
    logic                w_unused;

    assign w_req_addr   = bus.addr[MEM_AW-1:0];
    // A strobe issued last cycle returns its byte now; flush discards it.
    assign w_capture_en = r_mem_rd_en & ~bus.flush;
    assign w_unused     = ^{bus.addr[ADDR_W-1:MEM_AW], w_word[WORD_W-1:WORD_W-BYTE_W]};

    fetch_byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (bus.flush),
        .i_capture_en (w_capture_en),
        .i_lane       (r_cap_lane),
        .i_din        (bus.mem_din),
        .o_word       (w_word)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_cap_lane_nxt   = r_cap_lane;
        w_base_nxt       = r_base;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_addr_nxt  = r_pend_addr;
        w_mem_a_nxt      = r_mem_a;
        w_mem_rd_en_nxt  = 1'b0;
        w_data_nxt       = r_data;
        w_data_ready_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.asking) begin
                    w_base_nxt  = w_req_addr;
                    w_idx_nxt   = '0;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_mem_a_nxt     = r_base + MEM_AW'(r_idx);
                w_mem_rd_en_nxt = 1'b1;
                w_cap_lane_nxt  = r_idx;
                w_idx_nxt       = r_idx + LANE_W'(1);
                if (r_idx == LANE_W'(WORD_BYTES - 1)) begin
                    w_state_nxt = DRAIN;
                end
                if (bus.asking) begin
                    w_pend_valid_nxt = 1'b1;
                    w_pend_addr_nxt  = w_req_addr;
                end
            end
            DRAIN: begin
                // Last byte arrives this cycle; bypass it straight into data.
                w_data_nxt       = {bus.mem_din, w_word[WORD_W-BYTE_W-1:0]};
                w_data_ready_nxt = 1'b1;
                w_pend_valid_nxt = 1'b0;
                w_idx_nxt        = '0;
                if (bus.asking) begin
                    w_base_nxt  = w_req_addr;
                    w_state_nxt = ISSUE;
                end else if (r_pend_valid) begin
                    w_base_nxt  = r_pend_addr;
                    w_state_nxt = ISSUE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Flush wins over everything; a coincident request starts fresh.
        if (bus.flush) begin
            w_pend_valid_nxt = 1'b0;
            w_idx_nxt        = '0;
            w_mem_rd_en_nxt  = 1'b0;
            w_data_nxt       = r_data;
            w_data_ready_nxt = 1'b0;
            if (bus.asking) begin
                w_base_nxt  = w_req_addr;
                w_state_nxt = ISSUE;
            end else begin
                w_state_nxt = IDLE;
            end
        end

        w_busy_nxt = (w_state_nxt != IDLE) | w_pend_valid_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_cap_lane   <= '0;
            r_base       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_mem_a      <= '0;
            r_mem_rd_en  <= 1'b0;
            r_data       <= '0;
            r_data_ready <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cap_lane   <= w_cap_lane_nxt;
            r_base       <= w_base_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_addr  <= w_pend_addr_nxt;
            r_mem_a      <= w_mem_a_nxt;
            r_mem_rd_en  <= w_mem_rd_en_nxt;
            r_data       <= w_data_nxt;
            r_data_ready <= w_data_ready_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign bus.mem_a      = r_mem_a;
    assign bus.mem_rd_en  = r_mem_rd_en;
    assign bus.data       = r_data;
    assign bus.data_ready = r_data_ready;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Directed bench for ifetch_mem_responder: byte RAM model plus hand-computed words.
module tb_ifetch_mem_responder;
    import ifetch_mem_pkg::*;

    localparam int unsigned AW = 18;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [7:0]  ram [0:(1<<AW)-1];
    logic [31:0] wrap_a [4];

    ifetch_mem_responder_if #(.MEM_AW(AW)) bus ();

    ifetch_mem_responder #(.MEM_AW(AW), .RD_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Byte presented for the currently driven (registered) RAM address.
    assign bus.mem_din = ram[bus.mem_a];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic req(input logic [31:0] a);
        bus.asking = 1'b1;
        bus.addr   = a;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst        = 1'b1;
        bus.flush  = 1'b0;
        bus.asking = 1'b0;
        bus.addr   = '0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
        ram[18'h01000] = 8'h13; ram[18'h01001] = 8'h05; ram[18'h01002] = 8'hA0; ram[18'h01003] = 8'h00;
        ram[18'h01004] = 8'h37; ram[18'h01005] = 8'h41; ram[18'h01006] = 8'h00; ram[18'h01007] = 8'h00;
        ram[18'h02000] = 8'h93; ram[18'h02001] = 8'h00; ram[18'h02002] = 8'h10; ram[18'h02003] = 8'h00;
        ram[18'h3FFFE] = 8'hEF; ram[18'h3FFFF] = 8'hBE; ram[18'h00000] = 8'hAD; ram[18'h00001] = 8'hDE;
        wrap_a[0] = 32'h3FFFE; wrap_a[1] = 32'h3FFFF; wrap_a[2] = 32'h00000; wrap_a[3] = 32'h00001;

        // Reset state
        cyc();
        chk("rst_data",  bus.data,       32'h0);
        chk("rst_ready", 32'(bus.data_ready), 32'h0);
        chk("rst_mem_a", 32'(bus.mem_a), 32'h0);
        chk("rst_rd_en", 32'(bus.mem_rd_en), 32'h0);
        chk("rst_busy",  32'(bus.busy),  32'h0);
        rst = 1'b0;

        // 1: single fetch at 0x1000
        req(32'h0000_1000);
        cyc();
        bus.asking = 1'b0;
        chk("t1_busy_e0",  32'(bus.busy), 32'h1);
        chk("t1_rd_en_e0", 32'(bus.mem_rd_en), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t1_mem_a",  32'(bus.mem_a), 32'h1000 + 32'(i));
            chk("t1_rd_en",  32'(bus.mem_rd_en), 32'h1);
            chk("t1_ready0", 32'(bus.data_ready), 32'h0);
        end
        cyc();
        chk("t1_ready", 32'(bus.data_ready), 32'h1);
        chk("t1_data",  bus.data, 32'h00A00513);
        chk("t1_rd_en_off", 32'(bus.mem_rd_en), 32'h0);
        chk("t1_busy_done", 32'(bus.busy), 32'h0);
        cyc();
        chk("t1_ready_drop", 32'(bus.data_ready), 32'h0);
        chk("t1_data_hold",  bus.data, 32'h00A00513);

        // 2: back-to-back via pending buffer
        req(32'h0000_1000);
        cyc();
        bus.asking = 1'b0;
        cyc();
        cyc();
        chk("t2_mem_a_i1", 32'(bus.mem_a), 32'h1001);
        req(32'h0000_1004);
        cyc();
        bus.asking = 1'b0;
        chk("t2_mem_a_i2", 32'(bus.mem_a), 32'h1002);
        chk("t2_busy_pend", 32'(bus.busy), 32'h1);
        cyc();
        chk("t2_mem_a_i3", 32'(bus.mem_a), 32'h1003);
        chk("t2_ready_pre", 32'(bus.data_ready), 32'h0);
        cyc();
        chk("t2_ready_a", 32'(bus.data_ready), 32'h1);
        chk("t2_data_a",  bus.data, 32'h00A00513);
        chk("t2_busy_gap", 32'(bus.busy), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t2_mem_a_b", 32'(bus.mem_a), 32'h1004 + 32'(i));
            chk("t2_rd_en_b", 32'(bus.mem_rd_en), 32'h1);
            chk("t2_ready_b0", 32'(bus.data_ready), 32'h0);
            chk("t2_busy_b",  32'(bus.busy), 32'h1);
        end
        cyc();
        chk("t2_ready_b", 32'(bus.data_ready), 32'h1);
        chk("t2_data_b",  bus.data, 32'h00004137);
        chk("t2_busy_end", 32'(bus.busy), 32'h0);
        cyc();
        chk("t2_ready_drop", 32'(bus.data_ready), 32'h0);

        // 3: flush at i=1 with a pending request
        req(32'h0000_2000);
        cyc();
        req(32'h0000_1004);
        cyc();
        bus.asking = 1'b0;
        chk("t3_mem_a_i0", 32'(bus.mem_a), 32'h2000);
        chk("t3_busy_pre", 32'(bus.busy), 32'h1);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        chk("t3_rd_en", 32'(bus.mem_rd_en), 32'h0);
        chk("t3_busy",  32'(bus.busy), 32'h0);
        chk("t3_ready", 32'(bus.data_ready), 32'h0);
        chk("t3_data",  bus.data, 32'h00004137);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t3_ready_quiet", 32'(bus.data_ready), 32'h0);
            chk("t3_busy_quiet",  32'(bus.busy), 32'h0);
        end

        // 4: flush + asking during DRAIN
        req(32'h0000_1000);
        cyc();
        bus.asking = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("t4_mem_a_drain", 32'(bus.mem_a), 32'h1003);
        req(32'h0000_2000);
        bus.flush = 1'b1;
        cyc();
        bus.asking = 1'b0;
        bus.flush  = 1'b0;
        chk("t4_ready_abort", 32'(bus.data_ready), 32'h0);
        chk("t4_data_hold",   bus.data, 32'h00004137);
        chk("t4_rd_en_off",   32'(bus.mem_rd_en), 32'h0);
        chk("t4_busy",        32'(bus.busy), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t4_mem_a",  32'(bus.mem_a), 32'h2000 + 32'(i));
            chk("t4_rd_en",  32'(bus.mem_rd_en), 32'h1);
            chk("t4_ready0", 32'(bus.data_ready), 32'h0);
        end
        cyc();
        chk("t4_ready", 32'(bus.data_ready), 32'h1);
        chk("t4_data",  bus.data, 32'h00100093);
        cyc();

        // 5: address wrap at top of RAM (upper request bits ignored)
        req(32'hABC3_FFFE);
        cyc();
        bus.asking = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t5_mem_a", 32'(bus.mem_a), wrap_a[i]);
        end
        cyc();
        chk("t5_ready", 32'(bus.data_ready), 32'h1);
        chk("t5_data",  bus.data, 32'hDEADBEEF);
        cyc();

        // 6: async reset mid-ISSUE, then a fresh fetch
        req(32'h0000_1000);
        cyc();
        bus.asking = 1'b0;
        cyc();
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("t6_data",  bus.data, 32'h0);
        chk("t6_ready", 32'(bus.data_ready), 32'h0);
        chk("t6_mem_a", 32'(bus.mem_a), 32'h0);
        chk("t6_rd_en", 32'(bus.mem_rd_en), 32'h0);
        chk("t6_busy",  32'(bus.busy), 32'h0);
        cyc();
        rst = 1'b0;
        req(32'h0000_1004);
        cyc();
        bus.asking = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t6_mem_a_new", 32'(bus.mem_a), 32'h1004 + 32'(i));
            chk("t6_ready0",    32'(bus.data_ready), 32'h0);
        end
        cyc();
        chk("t6_ready_new", 32'(bus.data_ready), 32'h1);
        chk("t6_data_new",  bus.data, 32'h00004137);
        chk("t6_busy_end",  32'(bus.busy), 32'h0);
        cyc();
        chk("t6_ready_drop", 32'(bus.data_ready), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_mem_responder.md
Name: ifetch_mem_responder

Overview:
- Memory-side responder for the instruction-fetch request interface.
- The fetch front end raises `asking` with a byte address. This block reads four consecutive bytes from the byte-wide unified RAM port and assembles them little-endian into a 32-bit word. It returns the word on `data` with a one-cycle `data_ready` pulse.
- It holds one pending request and aborts in-flight work on a pipeline flush.

Parameters:
- MEM_AW, 18, width of the byte-addressed RAM port; upper request address bits are ignored.
- RD_LAT, 1, RAM read latency in cycles; fixed at 1 for this revision, and any other value is a configuration error.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort from fetch unit (branch mispredict/redirect).
- asking  in  1  fetch request valid; single-cycle pulse per request.
- addr  in  32  fetch byte address, sampled when asking=1.
- mem_a  out  MEM_AW  RAM byte address.
- mem_rd_en  out  1  RAM read strobe.
- mem_din  in  8  RAM read data, valid RD_LAT cycles after strobe.
- data  out  32  assembled instruction word (byte at addr in [7:0]).
- data_ready  out  1  one-cycle pulse: `data` valid.
- busy  out  1  fetch in progress or request pending.

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE; pending cleared; byte counter = 0.
  - data = 0, data_ready = 0, mem_a = 0, mem_rd_en = 0, busy = 0.
- States: IDLE, ISSUE (byte index i = 0..3), DRAIN (final capture).
- IDLE:
  - asking=1 latches base = addr[MEM_AW-1:0] and moves to ISSUE with i=0.
  - asking=0 keeps mem_rd_en=0.
- ISSUE:
  - Each cycle drives mem_a = base+i (mod 2^MEM_AW, so addresses wrap at the top of the RAM) with mem_rd_en=1.
  - Byte i is captured from mem_din one cycle later into data_buf[8i+7:8i].
  - After i=3 is issued, move to DRAIN.
- DRAIN:
  - Captures byte 3, registers data = assembled word, data_ready=1.
  - If a request is pending, or asking=1 this cycle, that request is latched as the new base and the next state is ISSUE (back-to-back, no IDLE bubble). Otherwise the next state is IDLE.
- Timing, with edge E0 sampling asking=1:
  - mem_a = base+i is valid after edge E(i+1); mem_rd_en is high from E1 to E5.
  - Byte i is captured at E(i+2).
  - data and data_ready are registered at E5; data_ready drops at E6.
  - Latency is 5 cycles; throughput is one word per 5 cycles.
- data holds its last value until the next completion; data_ready is 0 except on completion cycles.
- Request while not IDLE:
  - Stored in the one-entry pending buffer (pend_valid, pend_addr).
  - A further request while pending overwrites pend_addr (newest wins).
- flush=1 at an edge:
  - Aborts the current fetch; no data_ready for it, including when flush coincides with DRAIN.
  - Clears pending and goes to IDLE, with mem_rd_en=0 in the following cycle.
- flush and asking at the same edge: the old work is discarded and the new request is accepted as a fresh fetch (ISSUE, i=0).
- Bytes returned after an abort are ignored; the capture index is reset by flush.
- busy = (state != IDLE) | pend_valid, registered.
- No partial-word/compressed handling: always 4 bytes. The fetch unit decides instruction size from data[1:0].

Decomposition:
- Shared package `ifetch_mem_pkg`:
  - state enum {IDLE, ISSUE, DRAIN};
  - WORD_BYTES = 4;
  - byte-lane index width 2.
- One natural sub-module, `fetch_byte_assembler`: lane shift register taking (capture_en, lane, mem_din, clear) and exposing the 32-bit word. It is reusable by the data-load path.
- The FSM and pending buffer stay in the top module.

Test Plan:
1. Reset, then asking=1, addr=0x0000_1000, RAM[0x1000..0x1003] = 13 05 A0 00. Expect mem_a = 0x1000..0x1003 on cycles 1–4, then data=0x00A00513 with data_ready high exactly in cycle 5, busy low after.
2. Back-to-back: a second asking (addr=0x1004) arrives during ISSUE i=2. Expect it held pending, mem_a=0x1004 the cycle after DRAIN, two data_ready pulses 5 cycles apart, and no IDLE gap.
3. Flush mid-fetch: flush at i=1 with a pending request present. Expect no data_ready, pending dropped, mem_rd_en=0 next cycle, busy=0, data unchanged.
4. Flush coincident with asking (addr=0x2000) during DRAIN of the 0x1000 fetch. Expect no pulse for 0x1000, then data=RAM word at 0x2000 five cycles later.
5. Wrap: addr=0x3FFFE with MEM_AW=18. Expect mem_a sequence 0x3FFFE, 0x3FFFF, 0x00000, 0x00001, with the word assembled in that byte order.
6. Async reset asserted mid-ISSUE between clock edges. Expect all outputs 0 immediately. After release, a fresh request completes normally with the 5-cycle latency.
